// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst initiator for a 64x8 single-port RAM with a
// synchronous write and a one-cycle registered read. Accepts burst commands,
// drives per-beat RAM strobes and re-times read data into a qualified stream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_WRITE | one RAM write per accepted write beat; wr_valid low stalls
// S_READ  | one RAM read issue per cycle
// S_DRAIN | no RAM access; last registered read beat emerges
// S_DONE  | one-cycle completion pulse, then back to idle
module ram_burst_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_wr,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_ram_en,
    output logic              o_ram_wr,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_indata,
    input  logic [DATA_W-1:0] i_ram_outdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Longest burst covers the whole address space exactly once.
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_p_valid;
    logic                r_p_last;
    logic [LEN_W-1:0]    w_len;
    logic                w_last;
    logic                w_step;

    assign w_len  = (i_cmd_len > MAX_LEN) ? MAX_LEN : i_cmd_len;
    assign w_last = (r_remaining == LEN_W'(1));

    assign o_busy     = (r_state != S_IDLE);
    assign o_rd_valid = r_p_valid;
    assign o_rd_last  = r_p_last;
    assign o_rd_data  = i_ram_outdata;

    // Next-state decode and per-cycle RAM strobe / handshake generation.
    always_comb begin
        w_next_state = r_state;
        o_cmd_ready  = 1'b0;
        o_wr_ready   = 1'b0;
        o_done       = 1'b0;
        o_ram_en     = 1'b0;
        o_ram_wr     = 1'b0;
        o_ram_addr   = '0;
        o_ram_indata = '0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    if (w_len == '0)
                        w_next_state = S_DONE;
                    else if (i_cmd_wr)
                        w_next_state = S_WRITE;
                    else
                        w_next_state = S_READ;
                end
            end
            S_WRITE: begin
                o_wr_ready = 1'b1;
                if (i_wr_valid) begin
                    o_ram_en     = 1'b1;
                    o_ram_wr     = 1'b1;
                    o_ram_addr   = r_cur_addr;
                    o_ram_indata = i_wr_data;
                    w_step       = 1'b1;
                    if (w_last)
                        w_next_state = S_DONE;
                end
            end
            S_READ: begin
                o_ram_en   = 1'b1;
                o_ram_addr = r_cur_addr;
                w_step     = 1'b1;
                if (w_last)
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: w_next_state = S_DONE;
            S_DONE: begin
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, burst counters and the one-deep read-response pipeline flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_p_valid   <= 1'b0;
            r_p_last    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_p_valid <= (r_state == S_READ);
            r_p_last  <= (r_state == S_READ) && w_last;
            if (r_state == S_IDLE && i_cmd_valid) begin
                r_cur_addr  <= i_cmd_addr;
                r_remaining <= w_len;
            end else if (w_step) begin
                // Address wraps naturally at the top of the RAM.
                r_cur_addr  <= r_cur_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bench for ram_burst_ctrl with a behavioural
// RAM, a shadow memory and a per-cycle timeline model of expected outputs.
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_wr, cmd_ready;
    logic [5:0] cmd_addr;
    logic [6:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_last, done, busy;
    logic [7:0] rd_data;
    logic       ram_en, ram_wr;
    logic [5:0] ram_addr;
    logic [7:0] ram_indata, ram_outdata;

    always #5 clk = ~clk;

    ram_burst_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_done(done), .o_busy(busy),
        .o_ram_en(ram_en), .o_ram_wr(ram_wr), .o_ram_addr(ram_addr),
        .o_ram_indata(ram_indata), .i_ram_outdata(ram_outdata)
    );

    // Behavioural 64x8 RAM: synchronous write, registered read, junk when idle.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_indata;
            else        ram_outdata   <= mem[ram_addr];
        end else begin
            ram_outdata <= 8'($urandom);
        end
    end

    typedef struct packed {
        logic       cmd_ready, wr_ready, rd_valid, rd_last, done, busy, ram_en, ram_wr;
        logic [5:0] ram_addr;
        logic [7:0] ram_indata, rd_data;
    } exp_t;

    exp_t       ex;
    bit         chk_en = 1'b0;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] shadow [64];
    logic [7:0] wbuf [64];
    logic [7:0] rd_q[$];
    int         wa_q[$];
    int         cyc = 0, acc_cyc = 0, done_lat = -1, en_cnt = 0, done_cnt = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, want, $time);
        end
    endtask

    // Compare DUT against the model every cycle; also capture observations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready",  cmd_ready,  ex.cmd_ready);
            chk("wr_ready",   wr_ready,   ex.wr_ready);
            chk("rd_valid",   rd_valid,   ex.rd_valid);
            chk("rd_last",    rd_last,    ex.rd_last);
            chk("done",       done,       ex.done);
            chk("busy",       busy,       ex.busy);
            chk("ram_en",     ram_en,     ex.ram_en);
            chk("ram_wr",     ram_wr,     ex.ram_wr);
            chk("ram_addr",   ram_addr,   ex.ram_addr);
            chk("ram_indata", ram_indata, ex.ram_indata);
            if (ex.rd_valid) chk("rd_data", rd_data, ex.rd_data);
        end
        if (ram_en && ram_wr) wa_q.push_back(int'(ram_addr));
        if (rd_valid) rd_q.push_back(rd_data);
        if (ram_en) en_cnt++;
        if (rst && cmd_valid && cmd_ready) acc_cyc = cyc;
        if (done) begin
            done_lat = cyc - acc_cyc;
            done_cnt++;
        end
        cyc++;
    end

    function automatic exp_t idle_exp();
        exp_t e = '0;
        e.cmd_ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t busy_exp();
        exp_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input bit wr, input int addr, input int len);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = 6'(addr);
        cmd_len   = 7'(len);
        wr_valid  = 1'b0;
        ex        = idle_exp();
        tick();
    endtask

    task automatic do_write(input int addr, input int len, input int stall_at, input int stall_n);
        int n = (len > 64) ? 64 : len;
        do_cmd(1'b1, addr, len);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    wr_valid    = 1'b0;
                    wr_data     = 8'($urandom);
                    cmd_valid   = 1'($urandom);
                    ex          = busy_exp();
                    ex.wr_ready = 1'b1;
                    tick();
                end
            end
            wr_valid      = 1'b1;
            wr_data       = wbuf[i];
            cmd_valid     = 1'($urandom);
            ex            = busy_exp();
            ex.wr_ready   = 1'b1;
            ex.ram_en     = 1'b1;
            ex.ram_wr     = 1'b1;
            ex.ram_addr   = 6'((addr + i) % 64);
            ex.ram_indata = wbuf[i];
            shadow[(addr + i) % 64] = wbuf[i];
            tick();
        end
        wr_valid  = 1'b0;
        cmd_valid = 1'($urandom);
        ex        = busy_exp();
        ex.done   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        ex        = idle_exp();
        tick();
    endtask

    task automatic do_read(input int addr, input int len, input int abort_at);
        int n = (len > 64) ? 64 : len;
        do_cmd(1'b0, addr, len);
        for (int k = 1; k <= n; k++) begin
            cmd_valid   = 1'($urandom);
            ex          = busy_exp();
            ex.ram_en   = 1'b1;
            ex.ram_addr = 6'((addr + k - 1) % 64);
            if (k >= 2) begin
                ex.rd_valid = 1'b1;
                ex.rd_data  = shadow[(addr + k - 2) % 64];
            end
            if (k == abort_at) rst = 1'b0;
            tick();
            if (k == abort_at) begin
                rst       = 1'b1;
                cmd_valid = 1'b0;
                ex        = idle_exp();
                tick();
                ex        = idle_exp();
                tick();
                return;
            end
        end
        if (n > 0) begin
            cmd_valid   = 1'($urandom);
            ex          = busy_exp();
            ex.rd_valid = 1'b1;
            ex.rd_last  = 1'b1;
            ex.rd_data  = shadow[(addr + n - 1) % 64];
            tick();
        end
        cmd_valid = 1'($urandom);
        ex        = busy_exp();
        ex.done   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        ex        = idle_exp();
        tick();
    endtask

    initial begin
        int d0;
        int wrap_exp [4];

        // Reset held for three cycles with random inputs.
        rst = 1'b0;
        ex  = idle_exp();
        for (int r = 0; r < 3; r++) begin
            cmd_valid = 1'($urandom); cmd_wr = 1'($urandom);
            cmd_addr = 6'($urandom); cmd_len = 7'($urandom);
            wr_valid = 1'($urandom); wr_data = 8'($urandom);
            tick();
            chk_en = 1'b1;
        end
        rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0;
        tick();

        // Write then read, addr 10 len 4.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
        do_write(10, 4, -1, 0);
        chk("wr4_done_lat", done_lat, 5);
        rd_q.delete();
        do_read(10, 4, -1);
        chk("rd4_count", rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            chk("rd4_beat0", rd_q[0], 8'hA0);
            chk("rd4_beat3", rd_q[3], 8'hA3);
        end
        chk("rd4_done_lat", done_lat, 6);

        // Wrap-around from 62.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'h11 + 8'(i);
        wa_q.delete();
        do_write(62, 4, -1, 0);
        wrap_exp = '{62, 63, 0, 1};
        chk("wrap_count", wa_q.size(), 4);
        if (wa_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("wrap_addr", wa_q[i], wrap_exp[i]);
        do_read(62, 4, -1);

        // Write stall between beats 2 and 3 of a len-5 write.
        for (int i = 0; i < 5; i++) wbuf[i] = 8'h50 + 8'(i);
        do_write(20, 5, 2, 2);
        chk("stall_done_lat", done_lat, 8);
        do_read(20, 5, -1);

        // Zero length: done in cycle 1, no RAM access.
        en_cnt = 0;
        do_write(7, 0, -1, 0);
        chk("len0_wr_done_lat", done_lat, 1);
        do_read(7, 0, -1);
        chk("len0_rd_done_lat", done_lat, 1);
        chk("len0_ram_en", en_cnt, 0);

        // Full 64-beat burst at addr 5 with data = address.
        for (int i = 0; i < 64; i++) wbuf[i] = 8'((5 + i) % 64);
        do_write(5, 64, -1, 0);
        do_read(5, 64, -1);
        rd_q.delete();
        do_read(5, 100, -1);
        chk("len100_rd_count", rd_q.size(), 64);
        if (rd_q.size() == 64) begin
            chk("len100_beat0", rd_q[0], 5);
            chk("len100_beat58", rd_q[58], 63);
            chk("len100_beat59", rd_q[59], 0);
        end
        chk("len100_done_lat", done_lat, 66);

        // Clamped write length.
        for (int i = 0; i < 64; i++) wbuf[i] = 8'hC0 ^ 8'(i);
        en_cnt = 0;
        do_write(5, 100, -1, 0);
        chk("len100_wr_beats", en_cnt, 64);
        do_read(0, 64, -1);

        // Reset during beat 3 of a len-8 read, then a normal read.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
        do_write(10, 4, -1, 0);
        d0 = done_cnt;
        do_read(10, 8, 3);
        chk("abort_no_done", done_cnt - d0, 0);
        rd_q.delete();
        do_read(10, 4, -1);
        chk("post_abort_count", rd_q.size(), 4);
        if (rd_q.size() == 4) chk("post_abort_beat1", rd_q[1], 8'hA1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst initiator for the team's 64×8 single-port RAM (synchronous write, one-cycle registered read, `outdata` undefined when not enabled). It accepts burst read/write commands over a valid/ready handshake, streams write data in, and generates the per-beat `en`/`wr`/`addr`/`indata` strobes. It also re-times the RAM's registered read data into a qualified response stream, so upstream logic never samples `outdata` on an invalid cycle.

## Interface
- `ADDR_W`, default 6: RAM address width; 64 locations.
- `DATA_W`, default 8: RAM data width.
- `LEN_W`, default 7: burst-length field width; legal lengths are 0..64.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-low reset; sampled on the `clk` rising edge.
- `cmd_valid` input, 1 bit: command request.
- `cmd_ready` output, 1 bit: controller can accept a command; high only in IDLE.
- `cmd_wr` input, 1 bit: 1 = write burst, 0 = read burst.
- `cmd_addr` input, ADDR_W: burst start address.
- `cmd_len` input, LEN_W: beat count, 0..64; values above 64 are clamped to 64.
- `wr_valid` input, 1 bit: write beat available.
- `wr_ready` output, 1 bit: write beat accepted this cycle.
- `wr_data` input, DATA_W: write beat data.
- `rd_valid` output, 1 bit: `rd_data` is valid this cycle.
- `rd_data` output, DATA_W: read beat data, a pass-through of `ram_outdata`.
- `rd_last` output, 1 bit: qualifies the final read beat.
- `done` output, 1 bit: one-cycle pulse at burst completion.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `ram_en` output, 1 bit: RAM enable.
- `ram_wr` output, 1 bit: RAM write select.
- `ram_addr` output, ADDR_W: RAM address.
- `ram_indata` output, DATA_W: RAM write data.
- `ram_outdata` input, DATA_W: RAM registered read data.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cur_addr`=`cmd_addr`, `remaining`=min(`cmd_len`,64), and the direction.
  - `remaining`=0 → DONE; else `cmd_wr`=1 → WRITE, `cmd_wr`=0 → READ.
- **WRITE:**
  - `wr_ready`=1.
  - Cycle with `wr_valid`=1: `ram_en`=1, `ram_wr`=1, `ram_addr`=`cur_addr`, `ram_indata`=`wr_data` (combinational), then `cur_addr`++ and `remaining`--.
  - Cycle with `wr_valid`=0: `ram_en`=0 and no state change (stall).
  - Final accepted beat → DONE.
- **READ:**
  - Every cycle: `ram_en`=1, `ram_wr`=0, `ram_addr`=`cur_addr`, then `cur_addr`++ and `remaining`--.
  - Each issue sets a one-deep pipeline flag `p_valid` (and `p_last` on the final issue) for the next cycle.
  - Final issue → DRAIN.
- **DRAIN:** no RAM access; lets the last read beat emerge; → DONE.
- **DONE:** `done`=1 for exactly one cycle; → IDLE.
- **Read response:** `rd_valid`=`p_valid`, `rd_last`=`p_last`, `rd_data`=`ram_outdata`. `rd_data` is don't-care whenever `rd_valid`=0. The read stream has no backpressure; the consumer must always accept.
- **RAM outputs outside WRITE/READ:** `ram_en`=0, `ram_wr`=0, `ram_addr`=0, `ram_indata`=0.
- **Address arithmetic:** modulo 64; address 63 is followed by 0 with no error.
- **Length 64:** touches every location exactly once.
- **Commands during a burst:** `cmd_valid` is ignored outside IDLE; the source must hold the command until `cmd_ready`.
- **Reset mid-burst (`rst`=0):** aborts the burst immediately. No `done` pulse; `p_valid` is cleared, so no stray `rd_valid`. A partially written region keeps the beats already written.

## Timing
- **Reset values:** state=IDLE; `cmd_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_last`=0, `done`=0, `busy`=0; all `ram_*` outputs 0; `cur_addr`=0, `remaining`=0, `p_valid`=0, `p_last`=0.
- **Command accept:** on edge E0. RAM strobes begin in the cycle after E0.
- **Write burst, N beats, no stalls:** beats occupy cycles 1..N, `done` in cycle N+1, `cmd_ready` again in cycle N+2. Each stall cycle adds one cycle.
- **Read burst, N beats:** issues in cycles 1..N, `rd_valid` in cycles 2..N+1 (one cycle after each issue), `rd_last` in cycle N+1, DRAIN in cycle N+1, `done` in cycle N+2.
- **Length 0:** `done` in cycle 1; no RAM access.
- **Throughput:** one beat per cycle sustained; back-to-back commands are separated by at least the DONE cycle plus one IDLE cycle.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random inputs → all outputs at their reset values, `cmd_ready`=1, `ram_en`=0.
- **Write then read:** write addr 10, len 4, data 0xA0..0xA3, then read addr 10, len 4 → `rd_data` 0xA0,0xA1,0xA2,0xA3 in consecutive cycles, `rd_last` on 0xA3, `done` 1 cycle after `rd_last`.
- **Wrap-around:** write addr 62, len 4, data 0x11..0x14 → `ram_addr` sequence 62,63,0,1; read back from addr 62 returns 0x11..0x14.
- **Write stall:** deassert `wr_valid` for 2 cycles between beats 2 and 3 of a len-5 write → `ram_en`=0 on the stall cycles, `done` at cycle 8, memory contents correct.
- **Edge lengths:** len=0 → `done` at cycle 1 with no `ram_en`. len=64 at addr 5 with data=addr → readback of all 64 locations matches. `cmd_len`=100 behaves exactly as 64.
- **Reset mid-read:** assert `rst`=0 during beat 3 of a len-8 read → next cycle `rd_valid`=0, no `done` pulse, `cmd_ready`=1 after reset release, and a subsequent read still works.
